// File: rtl/serial_frame_builder_pkg.sv
// Shared types and constants for the serial frame builder and its downstream detector.
package serial_frame_builder_pkg;

    localparam int unsigned SFB_LEN_W   = 8;
    localparam int unsigned SFB_PAT_LEN = 4;
    localparam logic [7:0]  SFB_PATTERN = 8'b0000_1011;

    typedef enum logic [2:0] {
        IDLE,
        PAT,
        LEN,
        PAY,
        PAR,
        DONE
    } sfb_state_t;

    // Number of payload bytes needed to carry n bits (ceil(n/8)).
    function automatic logic [5:0] sfb_byte_count(input logic [SFB_LEN_W-1:0] n);
        return 6'((9'(n) + 9'd7) >> 3);
    endfunction

endpackage

// File: rtl/serial_frame_builder_if.sv
// Request/payload handshake and serial output bundle of the frame builder.
interface serial_frame_builder_if;
    import serial_frame_builder_pkg::*;

    logic                 start;
    logic [SFB_LEN_W-1:0] len;
    logic [7:0]           data;
    logic                 data_valid;
    logic                 data_ready;
    logic                 serout;
    logic                 busy;
    logic                 done;
    logic                 underrun;

    modport master (
        output start, len, data, data_valid,
        input  data_ready, serout, busy, done, underrun
    );

    modport slave (
        input  start, len, data, data_valid,
        output data_ready, serout, busy, done, underrun
    );

endinterface

// File: rtl/serial_frame_builder_byte_buffer.sv
// sfb_byte_buffer: holding + shift register feeding payload bits, with
// valid/ready fetch accounting and empty (underrun) detection.
module sfb_byte_buffer
    import serial_frame_builder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [SFB_LEN_W-1:0] len_in,
    input  logic                 active_nxt,
    input  logic                 pay_en,
    input  logic [2:0]           pos,
    input  logic [7:0]           data,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 bit_c,
    output logic                 empty_c
);

    logic [7:0] sh_q, sh_d;
    logic [7:0] hold_q, hold_d;
    logic       sh_vld_q, sh_vld_d;
    logic       hold_vld_q, hold_vld_d;
    logic [5:0] fetch_q, fetch_d;
    logic       ready_q, ready_d;
    logic       xfer;

    assign data_ready = ready_q;
    assign xfer       = data_valid && ready_q;

    // Bit selection, register movement and fetch bookkeeping.
    always_comb begin
        sh_d       = sh_q;
        sh_vld_d   = sh_vld_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        fetch_d    = fetch_q;
        bit_c      = 1'b0;
        empty_c    = 1'b0;

        if (pay_en) begin
            if (sh_vld_q) begin
                bit_c = sh_q[7];
                sh_d  = {sh_q[6:0], 1'b0};
                if (pos == 3'd7) begin
                    sh_d       = hold_q;
                    sh_vld_d   = hold_vld_q;
                    hold_vld_d = 1'b0;
                end
            end else if (hold_vld_q) begin
                // Late byte: join in at the bit position already reached.
                bit_c      = hold_q[3'd7 - pos];
                hold_vld_d = 1'b0;
                if (pos != 3'd7) begin
                    sh_d     = hold_q << (pos + 3'd1);
                    sh_vld_d = 1'b1;
                end
            end else begin
                empty_c = 1'b1;
            end
        end else if (!sh_vld_q && hold_vld_q) begin
            sh_d       = hold_q;
            sh_vld_d   = 1'b1;
            hold_vld_d = 1'b0;
        end

        if (xfer) begin
            hold_d     = data;
            hold_vld_d = 1'b1;
            fetch_d    = fetch_q - 6'd1;
        end

        if (load) begin
            sh_vld_d   = 1'b0;
            hold_vld_d = 1'b0;
            fetch_d    = sfb_byte_count(len_in);
        end

        ready_d = active_nxt && !hold_vld_d && (fetch_d != 6'd0);
    end

    // Buffer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q       <= '0;
            hold_q     <= '0;
            sh_vld_q   <= 1'b0;
            hold_vld_q <= 1'b0;
            fetch_q    <= '0;
            ready_q    <= 1'b0;
        end else begin
            sh_q       <= sh_d;
            hold_q     <= hold_d;
            sh_vld_q   <= sh_vld_d;
            hold_vld_q <= hold_vld_d;
            fetch_q    <= fetch_d;
            ready_q    <= ready_d;
        end
    end

endmodule

// File: rtl/serial_frame_builder.sv
// Serial frame builder: start pattern, 8-bit length, payload bits, optional parity.
// Define SERIAL_FRAME_PARITY_EN to append an even-parity bit over length and payload.
module serial_frame_builder
    import serial_frame_builder_pkg::*;
#(
    parameter int unsigned PAT_LEN = SFB_PAT_LEN,
    parameter logic [7:0]  PATTERN = SFB_PATTERN
)
(
    input  logic                   clk,
    input  logic                   rst,
    serial_frame_builder_if.slave  bus
);

`ifdef SERIAL_FRAME_PARITY_EN
    localparam sfb_state_t TAIL = PAR;
`else
    localparam sfb_state_t TAIL = DONE;
`endif

    sfb_state_t           state_q, state_d;
    logic [7:0]           idx_q, idx_d;
    logic [SFB_LEN_W-1:0] len_q, len_d;
    logic                 serout_q, serout_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 underrun_q, underrun_d;
`ifdef SERIAL_FRAME_PARITY_EN
    logic                 par_q, par_d;
`endif
    logic                 load_c, pay_en_c, bit_c, empty_c, ready;

    assign bus.serout     = serout_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.underrun   = underrun_q;
    assign bus.data_ready = ready;

    sfb_byte_buffer u_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (load_c),
        .len_in     (bus.len),
        .active_nxt (busy_d),
        .pay_en     (pay_en_c),
        .pos        (idx_q[2:0]),
        .data       (bus.data),
        .data_valid (bus.data_valid),
        .data_ready (ready),
        .bit_c      (bit_c),
        .empty_c    (empty_c)
    );

    // Next-state, bit counter and control strobes.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        done_d   = 1'b0;
        load_c   = 1'b0;
        pay_en_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load_c  = 1'b1;
                    len_d   = bus.len;
                    idx_d   = '0;
                    state_d = PAT;
                end
            end
            PAT: begin
                if (idx_q == 8'(PAT_LEN - 1)) begin
                    idx_d   = '0;
                    state_d = LEN;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            LEN: begin
                if (idx_q == 8'd7) begin
                    idx_d   = '0;
                    state_d = (len_q != '0) ? PAY : TAIL;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            PAY: begin
                pay_en_c = 1'b1;
                if (idx_q == len_q - 8'd1) begin
                    idx_d   = '0;
                    state_d = TAIL;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
`ifdef SERIAL_FRAME_PARITY_EN
            PAR:     state_d = DONE;
`endif
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d inside {PAT, LEN, PAY, PAR};
    end

    // Serial bit selection, underrun flag and running parity.
    always_comb begin
        serout_d   = 1'b0;
        underrun_d = 1'b0;
        case (state_q)
            PAT:     serout_d = PATTERN[3'(PAT_LEN - 1) - idx_q[2:0]];
            LEN:     serout_d = len_q[3'd7 - idx_q[2:0]];
            PAY: begin
                serout_d   = bit_c;
                underrun_d = empty_c;
            end
`ifdef SERIAL_FRAME_PARITY_EN
            PAR:     serout_d = par_q;
`endif
            default: serout_d = 1'b0;
        endcase
`ifdef SERIAL_FRAME_PARITY_EN
        par_d = par_q;
        if (state_q == IDLE) begin
            par_d = 1'b0;
        end else if (state_q == LEN || state_q == PAY) begin
            par_d = par_q ^ serout_d;
        end
`endif
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            serout_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            serout_q   <= serout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
`ifdef SERIAL_FRAME_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_frame_builder.sv
// Self-checking bench for serial_frame_builder: vector table, corner sequences, random frames.
module tb_serial_frame_builder;

    localparam int         PAT_LEN = 4;
    localparam logic [3:0] PAT     = 4'b1011;
`ifdef SERIAL_FRAME_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_frame_builder_if bus();
    serial_frame_builder dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int          len;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          avail1;
        logic [15:0] exp_pay;
        int          exp_ur;
        int          exp_xfer;
    } vec_t;

    vec_t       vecs[6];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] prod_bytes[$];
    int         prod_avail[$];
    int         prod_dly[$];
    bit         cap_q[$];
    bit         exp_q[$];
    bit         pay_q[$];
    int         done_cnt, done_cyc, ur_cnt, xfer_cnt, busy_cnt;

    function automatic void chk(string name, int got, int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endfunction

    // Reference frame: pattern, length MSB first, payload bits, optional even parity.
    function automatic void build_exp(int len);
        logic [7:0] lb;
        bit         par;
        lb  = 8'(len);
        par = 1'b0;
        exp_q.delete();
        for (int i = PAT_LEN - 1; i >= 0; i--) exp_q.push_back(PAT[i]);
        for (int i = 7; i >= 0; i--) begin
            exp_q.push_back(lb[i]);
            par ^= lb[i];
        end
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(pay_q[i]);
            par ^= pay_q[i];
        end
        if (P == 1) exp_q.push_back(par);
    endfunction

    function automatic void pay_from_bytes(int len);
        logic [7:0] b;
        pay_q.delete();
        for (int i = 0; i < len; i++) begin
            b = prod_bytes[i / 8];
            pay_q.push_back(b[7 - (i % 8)]);
        end
    endfunction

    function automatic void chk_frame(string name);
        int bad;
        bad = -1;
        n_tests++;
        if (cap_q.size() != exp_q.size()) bad = 0;
        else
            for (int i = 0; i < cap_q.size(); i++)
                if (bad < 0 && cap_q[i] != exp_q[i]) bad = i;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s frame: bit %0d got %0d expected %0d (sizes %0d/%0d)", name, bad,
                     (bad < cap_q.size()) ? int'(cap_q[bad]) : -1,
                     (bad < exp_q.size()) ? int'(exp_q[bad]) : -1, cap_q.size(), exp_q.size());
        end
    endfunction

    // One frame: request, feed bytes, capture serout and event counts over a bounded window.
    task automatic run_frame(input int len, input int mid);
        int L    = PAT_LEN + 8 + len + P;
        int need = (len + 7) / 8;
        int k    = 0;
        int rcnt = 0;
        cap_q.delete();
        done_cnt = 0; done_cyc = -1; ur_cnt = 0; xfer_cnt = 0; busy_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = 8'(len);
        bus.data_valid = 1'b0;
        for (int c = 0; c <= L + 2; c++) begin
            @(negedge clk);
            bus.start = (c == mid);
            if (c == 0) bus.len = ~8'(len);
            if (c >= 1 && c <= L) cap_q.push_back(bus.serout);
            if (bus.done) begin done_cnt++; done_cyc = c; end
            if (bus.underrun) ur_cnt++;
            if (bus.busy) busy_cnt++;
            if (k < need) begin
                bus.data       = prod_bytes[k];
                bus.data_valid = (c >= prod_avail[k]) && bus.data_ready && (rcnt >= prod_dly[k]);
            end else begin
                bus.data       = 8'hEE;
                bus.data_valid = 1'b1;
            end
            if (bus.data_valid && bus.data_ready) begin
                xfer_cnt++; k++; rcnt = 0;
            end else if (bus.data_ready) begin
                rcnt++;
            end
        end
        bus.data_valid = 1'b0;
        bus.start      = 1'b0;
    endtask

    task automatic check_frame(input string name, input int len, input int exp_ur, input int exp_xfer);
        int L = PAT_LEN + 8 + len + P;
        build_exp(len);
        chk_frame(name);
        chk({name, " done_cycle"}, done_cyc, L + 1);
        chk({name, " done_count"}, done_cnt, 1);
        chk({name, " underruns"}, ur_cnt, exp_ur);
        chk({name, " transfers"}, xfer_cnt, exp_xfer);
        chk({name, " busy_cycles"}, busy_cnt, L);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int L, need, mid, dcnt, bcnt, scnt, gap;
        int dq[$];
        bit s[$];

        vecs[0] = '{8,  8'hA5, 8'h00, 0,  16'hA500, 0, 1};
        vecs[1] = '{0,  8'h00, 8'h00, 0,  16'h0000, 0, 0};
        vecs[2] = '{12, 8'hF0, 8'h3C, 0,  16'hF030, 0, 2};
        vecs[3] = '{16, 8'h5A, 8'hC3, 22, 16'h5A03, 3, 2};
        vecs[4] = '{3,  8'hE0, 8'h00, 0,  16'hE000, 0, 1};
        vecs[5] = '{9,  8'hFF, 8'h80, 0,  16'hFF80, 0, 2};

        bus.start = 1'b0; bus.len = '0; bus.data = '0; bus.data_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset serout", bus.serout, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset underrun", bus.underrun, 0);
        chk("reset data_ready", bus.data_ready, 0);

        // Directed vector table.
        foreach (vecs[i]) begin
            prod_bytes.delete(); prod_avail.delete(); prod_dly.delete();
            prod_bytes.push_back(vecs[i].b0); prod_avail.push_back(0);              prod_dly.push_back(0);
            prod_bytes.push_back(vecs[i].b1); prod_avail.push_back(vecs[i].avail1); prod_dly.push_back(0);
            pay_q.delete();
            for (int b = 0; b < vecs[i].len; b++) pay_q.push_back(vecs[i].exp_pay[15 - b]);
            run_frame(vecs[i].len, -1);
            check_frame($sformatf("vec%0d", i), vecs[i].len, vecs[i].exp_ur, vecs[i].exp_xfer);
        end

        // Reset mid-payload: abort immediately, no done afterwards.
        bus.data = 8'h77; bus.data_valid = 1'b1;
        @(negedge clk);
        bus.start = 1'b1; bus.len = 8'd16;
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            bus.start = (c == 3);
        end
        chk("pre-reset busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("abort serout", bus.serout, 0);
        chk("abort busy", bus.busy, 0);
        chk("abort done", bus.done, 0);
        chk("abort data_ready", bus.data_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0; bus.data_valid = 1'b0; bus.start = 1'b0;
        dcnt = 0; bcnt = 0; scnt = 0;
        repeat (30) begin
            @(negedge clk);
            dcnt += int'(bus.done); bcnt += int'(bus.busy); scnt += int'(bus.serout);
        end
        chk("post-abort done pulses", dcnt, 0);
        chk("post-abort busy cycles", bcnt, 0);
        chk("post-abort serout ones", scnt, 0);
        prod_bytes.delete(); prod_avail.delete(); prod_dly.delete();
        prod_bytes.push_back(8'h3C); prod_avail.push_back(0); prod_dly.push_back(2);
        prod_bytes.push_back(8'h81); prod_avail.push_back(0); prod_dly.push_back(1);
        pay_from_bytes(16);
        run_frame(16, -1);
        check_frame("after-reset", 16, 0, 2);

        // Back-to-back with start held high.
        L = PAT_LEN + 8 + 8 + P;
        bus.data = 8'hA5; bus.data_valid = 1'b1;
        @(negedge clk);
        bus.start = 1'b1; bus.len = 8'd8;
        s.delete(); dq.delete();
        for (int c = 0; c <= 2 * L + 4; c++) begin
            @(negedge clk);
            if (c == L + 2) bus.start = 1'b0;
            s.push_back(bus.serout);
            if (bus.done) dq.push_back(c);
        end
        bus.data_valid = 1'b0;
        chk("b2b done count", dq.size(), 2);
        chk("b2b first done", (dq.size() > 0) ? dq[0] : -1, L + 1);
        chk("b2b second done", (dq.size() > 1) ? dq[1] : -1, 2 * L + 3);
        gap = int'(s[L + 1]) + int'(s[L + 2]);
        chk("b2b gap ones", gap, 0);
        prod_bytes.delete(); prod_bytes.push_back(8'hA5);
        pay_from_bytes(8);
        build_exp(8);
        cap_q.delete();
        for (int c = 1; c <= L; c++) cap_q.push_back(s[c]);
        chk_frame("b2b frame1");
        cap_q.delete();
        for (int c = L + 3; c <= 2 * L + 2; c++) cap_q.push_back(s[c]);
        chk_frame("b2b frame2");

        // Randomised frames, prompt producer, stray start mid-frame.
        for (int r = 0; r < 25; r++) begin
            int len;
            len  = int'($urandom_range(0, 40));
            need = (len + 7) / 8;
            prod_bytes.delete(); prod_avail.delete(); prod_dly.delete();
            for (int k = 0; k < need; k++) begin
                prod_bytes.push_back(8'($urandom));
                prod_avail.push_back(0);
                prod_dly.push_back(int'($urandom_range(0, 6)));
            end
            pay_from_bytes(len);
            L   = PAT_LEN + 8 + len + P;
            mid = int'($urandom_range(2, L - 3));
            run_frame(len, mid);
            check_frame($sformatf("rand%0d len%0d", r, len), len, 0, need);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_frame_builder.md
# serial_frame_builder

Upstream framing stage for the serial transmitter path. It accepts a payload length and a stream of payload bytes on a valid/ready handshake, then emits a single-bit serial frame on `serout`: start pattern, 8-bit length field, payload bits, and an optional parity bit. Its `serout` drives the transmitter path's `serin` directly, so the downstream pattern detector and length collector lock onto every frame it produces.

## Interface
- `PAT_LEN`, 4: start-pattern width in bits, 1..8.
- `PATTERN`, 4'b1011: start pattern, sent MSB first.

- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: frame request; sampled only in IDLE.
- `len` in 8: payload bit count, 0..255; captured with `start`.
- `data` in 8: payload byte, MSB sent first.
- `data_valid` in 1: `data` is valid.
- `data_ready` out 1: block accepts `data` this cycle.
- `serout` out 1: serial output.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse after the last frame bit.
- `underrun` out 1: one-cycle pulse per payload bit sent without data.

## Operation
- States: IDLE, PAT, LEN, PAY, PAR, DONE.
- **IDLE**
  - `serout`=0, `busy`=0.
  - `start`=1 captures `len`, loads `PATTERN`, and moves to PAT.
- **PAT**: emits `PATTERN[PAT_LEN-1]` down to bit 0, one bit per cycle, then moves to LEN.
- **LEN**
  - Emits `len[7]` down to `len[0]`.
  - Then moves to PAY if `len`≠0; else to PAR (parity enabled) or DONE.
- **PAY**
  - Emits `len` bits, MSB of each byte first.
  - The last byte uses only its top `len mod 8` bits (all 8 if that is 0).
  - Then moves to PAR or DONE.
- **PAR**: emits one parity bit, then moves to DONE.
- **DONE**
  - `serout`=0, `done`=1 for one cycle.
  - Returns to IDLE; a new `start` is honoured from that IDLE cycle.
- Buffering: 8-bit shift register plus one 8-bit holding register.
  - `data_ready` = `busy` and holding register empty and bytes still to fetch > 0.
  - Bytes to fetch = ceil(`len`/8), decremented on each transfer (`data_valid`&&`data_ready`).
  - Surplus bytes are never requested.
- Underrun: payload bit due while both registers are empty.
  - `serout`=0 for that bit and `underrun` pulses.
  - The bit counter still advances, so frame length is never altered.
  - A late byte is applied to the remaining bits, starting from the bit position the counter has reached.
- `start` while `busy` is ignored.
- `busy` is high in PAT, LEN, PAY and PAR.

## Timing
- Reset values: `serout`=0, `busy`=0, `done`=0, `underrun`=0, `data_ready`=0, state IDLE, all counters and registers cleared.
- `rst` mid-frame aborts immediately. The partial frame is not completed and no `done` pulse is produced.
- All outputs are registered; `serout` changes only on `clk` rising edges.
- First pattern bit on `serout` appears one cycle after the `start` sample edge.
- Frame length = `PAT_LEN` + 8 + `len` + P bits (P=1 with parity, else 0). `done` follows the last bit by one cycle.
- `data_ready` rises in the first PAT cycle. Bytes may be preloaded during PAT and LEN, so the first payload bit needs no bubble.
- The holding register refills while the shift register drains. A producer supplying each byte within 7 cycles of `data_ready` never underruns.
- A byte moves from holding to shift register in the same cycle the shift register's last needed bit is emitted.

## Configuration
- `SERIAL_FRAME_PARITY_EN` defined:
  - PAR state present.
  - Parity bit = XOR of the transmitted length and payload bits (even parity over those fields).
  - Zero bits substituted on underrun count as 0.
- Undefined: PAR state and parity logic removed; LEN/PAY go straight to DONE.

## Structure
- The shared package holds:
  - state enum `sfb_state_t` {IDLE, PAT, LEN, PAY, PAR, DONE};
  - `SFB_LEN_W`=8;
  - default `PATTERN` / `PAT_LEN` constants shared with the downstream detector.
- One sub-module, `sfb_byte_buffer`: the holding register plus shift register, valid/ready logic, and empty/underrun detection.
- The FSM and bit counters live in the top level.

## Test plan
- `len`=8, byte 0xA5 given on first `data_ready`, parity off → `serout` = 1011, 00001000, 10100101; `done` pulses at cycle 21 after `start`.
- `len`=0, parity on → 1011, 00000000, 0, then `done`; `data_ready` never asserts.
- `len`=12, bytes 0xF0 then 0x3C → payload 11110000 0011; second byte's low nibble ignored; exactly 2 transfers.
- `len`=16, second byte withheld until 3 cycles past need → 3 `underrun` pulses, 3 zero bits; frame still 28 bits; `done` on time.
- `start` pulsed mid-frame, then `rst` asserted during PAY → first ignored; on reset `serout`=0, `busy`=0, no `done`; a fresh `start` produces a full correct frame.
- Back-to-back: `start` held high → frames separated by exactly one DONE cycle plus one IDLE cycle.
